div_seq: RTL and testbench



---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_seq_step.sv | 24 ++
 rtl/div_seq.sv | 160 ++++++++++++++++
 tb/tb_div_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants and state encoding for the sequential integer divider.
package div_seq_pkg;

  localparam int REG_BUS = 32;
  localparam int DOUBLE_REG_BUS = 2 * REG_BUS;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring-division step on the {partial remainder, dividend} working register.
module div_step
  import div_seq_pkg::*;
#(
  parameter int WIDTH = REG_BUS
) (
  input  logic [2*WIDTH:0] work_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] work_o
);

  logic [WIDTH+1:0] diff_s;

  // The shifted partial remainder is work_i[2W:W-1]; a clear top bit of the difference means it fits.
  always_comb begin
    diff_s = work_i[2*WIDTH:WIDTH-1] - {2'b00, divisor_i};
    if (!diff_s[WIDTH+1]) begin
      work_o = {diff_s[WIDTH:0], work_i[WIDTH-2:0], 1'b1};
    end else begin
      work_o = {work_i[2*WIDTH-1:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: latches operands, iterates div_step,
// applies sign and divide-by-zero rules, and holds {remainder, quotient} with a ready flag.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = REG_BUS,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [2*WIDTH:0]   step_s;
  logic [WIDTH-1:0]   abs1_s, abs2_s, quot_s, rem_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      res_q      <= '0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      res_q      <= res_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Magnitudes of the incoming operands and sign fix-up of the final step's output.
  always_comb begin
    abs1_s = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    abs2_s = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quot_s = neg_quot_q ? -step_s[WIDTH-1:0] : step_s[WIDTH-1:0];
    rem_s  = neg_rem_q ? -step_s[2*WIDTH-1:WIDTH] : step_s[2*WIDTH-1:WIDTH];
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    res_d      = res_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_i) begin
          neg_quot_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_rem_d  = signed_div_i & opdata1_i[WIDTH-1];
          cnt_d      = '0;
          if (opdata2_i == '0) begin
            // Keep the raw dividend: it becomes the remainder unchanged.
            state_d   = DIV_BY_ZERO;
            work_d    = {{(WIDTH+1){1'b0}}, opdata1_i};
            divisor_d = '0;
          end else begin
            state_d   = DIV_ON;
            work_d    = {{(WIDTH+1){1'b0}}, abs1_s};
            divisor_d = abs2_s;
          end
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BY_ZERO: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          res_d   = {work_q[WIDTH-1:0], {WIDTH{1'b1}}};
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          work_d = step_s;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DIV_END;
            res_d   = {rem_s, quot_s};
          end else begin
            state_d = DIV_ON;
          end
        end
      end
      DIV_END: begin
        if (annul_i) begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (start_i == DIV_START) begin
          state_d  = DIV_END;
          result_d = res_q;
          ready_d  = DIV_RESULT_READY;
        end else begin
          state_d  = DIV_FREE;
          result_d = '0;
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        result_d = '0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus randomized operations
// checked against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad = 0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V DIV/DIVU/REM/REMU semantics, returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Starts an operation, scrambles operands after acceptance, waits for ready (lat=-1 on timeout).
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = $urandom_range(0, 1);
    lat = -1;
    res = '0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (ready_o) begin
        lat = n;
        res = result_o;
        break;
      end
    end
  endtask

  task automatic drop_start;
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset: ready=%b result=%h, want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_basic;
    int lat;
    logic [63:0] res;
    do_op(1'b0, 32'd100, 32'd7, lat, res);
    total++;
    if (lat !== 33) begin
      bad++;
      $display("FAIL udiv_latency: got %0d want 33", lat);
    end
    total++;
    if (res !== {32'd2, 32'd14}) begin
      bad++;
      $display("FAIL udiv_100_7: got %h want %h", res, {32'd2, 32'd14});
    end
    drop_start();
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL udiv_release: ready=%b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_signed;
    int lat;
    logic [63:0] res;
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res);
    total++;
    if (lat !== 33 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL sdiv_m7_2: got %h lat %0d want %h lat 33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    end
    drop_start();
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, lat, res);
    total++;
    if (lat !== 33 || res !== {32'h0000_0001, 32'h7FFF_FFFC}) begin
      bad++;
      $display("FAIL udiv_fff9_2: got %h lat %0d want %h lat 33", res, lat, {32'h0000_0001, 32'h7FFF_FFFC});
    end
    drop_start();
  endtask

  task automatic test_div_by_zero;
    int lat;
    logic [63:0] res;
    do_op(1'b1, 32'h1234_5678, 32'd0, lat, res);
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL dbz_latency: got %0d want 2", lat);
    end
    total++;
    if (res !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      bad++;
      $display("FAIL dbz_result: got %h want %h", res, {32'h1234_5678, 32'hFFFF_FFFF});
    end
    drop_start();
  endtask

  task automatic test_overflow;
    int lat;
    logic [63:0] res;
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    total++;
    if (lat !== 33 || res !== {32'd0, 32'h8000_0000}) begin
      bad++;
      $display("FAIL overflow: got %h lat %0d want %h lat 33", res, lat, {32'd0, 32'h8000_0000});
    end
    drop_start();
  endtask

  task automatic test_annul;
    int lat;
    int seen;
    logic [63:0] res;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL annul_outputs: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    annul_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL annul_no_ready: ready cycles %0d want 0", seen);
    end
    do_op(1'b0, 32'd50, 32'd5, lat, res);
    total++;
    if (lat !== 33 || res !== {32'd0, 32'd10}) begin
      bad++;
      $display("FAIL after_annul_50_5: got %h lat %0d want %h lat 33", res, lat, {32'd0, 32'd10});
    end
    drop_start();
  endtask

  task automatic test_end_hold;
    int lat;
    int unstable;
    logic [63:0] res;
    do_op(1'b1, 32'hFFFF_FC18, 32'd7, lat, res);
    total++;
    if (lat !== 33 || res !== ref_div(1'b1, 32'hFFFF_FC18, 32'd7)) begin
      bad++;
      $display("FAIL hold_initial: got %h lat %0d want %h lat 33", res, lat, ref_div(1'b1, 32'hFFFF_FC18, 32'd7));
    end
    unstable = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      @(posedge clk);
      #1;
      if (ready_o !== 1'b1 || result_o !== res) unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL hold_stable: unstable cycles %0d want 0", unstable);
    end
    drop_start();
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL hold_release: ready=%b result=%h want 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i = 32'd999;
    opdata2_i = 32'd4;
    start_i = 1'b1;
    @(posedge clk);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (ready_o) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL reset_mid_residual: ready cycles %0d want 0", seen);
    end
  endtask

  task automatic test_random;
    int lat;
    int want_lat;
    bit sgn;
    logic [31:0] a, b;
    logic [63:0] res;
    logic [63:0] want;
    for (int i = 0; i < 24; i++) begin
      sgn = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (i == 0) begin
        a = 32'h8000_0000;
        b = 32'd1;
      end
      want = ref_div(sgn, a, b);
      want_lat = (b == 32'd0) ? 2 : 33;
      do_op(sgn, a, b, lat, res);
      total++;
      if (lat !== want_lat || res !== want) begin
        bad++;
        $display("FAIL random_%0d: s=%0d %h/%h got %h lat %0d want %h lat %0d",
                 i, sgn, a, b, res, lat, want, want_lat);
      end
      drop_start();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_annul();
    test_end_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
